host_cmd_link: RTL and testbench
================================

HOST_CMD_LINK -- requirements
Module: host_cmd_link

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000, is the number of idle clocks after which a partial command is discarded.
REQ-002 Parameter NUM_CMD_BYTES, default 3, is the number of bytes per command; it is fixed at 3 for this design.
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_data  in  8  byte from the UART receiver.
REQ-006 rx_rdy  in  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-007 cmd  out  24  assembled host command for the digital core.
REQ-008 cmd_rdy  out  1  cmd is valid and held.
REQ-009 clr_cmd_rdy  in  1  core has consumed cmd.
REQ-010 resp_data  in  8  response byte from the core.
REQ-011 send_resp  in  1  one-cycle pulse requesting transmission of resp_data.
REQ-012 resp_sent  out  1  one-cycle pulse when the response byte has left the transmitter.
REQ-013 tx_data  out  8  byte to the UART transmitter.
REQ-014 trmt  out  1  one-cycle pulse starting a UART transmission.
REQ-015 tx_done  in  1  one-cycle pulse from the UART transmitter at end of frame.
REQ-016 resp_busy  out  1  a response is in flight.
REQ-017 rx_overrun  out  1  sticky flag: a byte was dropped because cmd_rdy was high.

Function
REQ-018 A 2-bit byte index counts 0..2; the byte at index 0 goes to cmd[23:16], index 1 to cmd[15:8], index 2 to cmd[7:0] (MSB first).
REQ-019 On the third accepted byte, cmd_rdy shall rise on the next clock edge, the byte index shall return to 0, and cmd shall already hold all 24 bits.
REQ-020 While cmd_rdy=1, cmd shall not change, and any rx_rdy byte shall be dropped and set rx_overrun.
REQ-021 clr_cmd_rdy shall deassert cmd_rdy on the next edge and clear rx_overrun in the same edge.
REQ-022 If clr_cmd_rdy and rx_rdy coincide while cmd_rdy=1, the byte shall be accepted as index 0 and rx_overrun shall not be set.
REQ-023 clr_cmd_rdy while cmd_rdy=0 shall have no effect.
REQ-024 With byte index 1 or 2, if no rx_rdy arrives for TIMEOUT_CYCLES consecutive clocks, the index shall reset to 0; cmd and cmd_rdy are unaffected.
REQ-025 The timeout counter shall be cleared on every accepted byte and held at 0 while the index is 0.
REQ-026 The TX FSM has two states, TX_IDLE and TX_WAIT.
REQ-027 In TX_IDLE, send_resp shall register resp_data into tx_data, pulse trmt high for exactly the next cycle, and move the FSM to TX_WAIT.
REQ-028 In TX_WAIT, tx_done shall pulse resp_sent for one cycle on the next edge and return the FSM to TX_IDLE.
REQ-029 resp_busy shall equal (state==TX_WAIT).
REQ-030 send_resp in TX_WAIT, and tx_done in TX_IDLE, shall be ignored.
REQ-031 tx_data shall hold its value until the next accepted send_resp.
REQ-032 The RX and TX paths are independent; simultaneous activity on both shall not stall either path.

Reset
REQ-033 On rst, the following shall apply: cmd=24'h000000, cmd_rdy=0, rx_overrun=0, byte index=0, timeout count=0, tx_data=8'h00, trmt=0, resp_sent=0, TX state=TX_IDLE.
REQ-034 Reset asserted mid-command or mid-response shall abandon the transaction.
REQ-035 A tx_done arriving after such a reset shall produce no resp_sent.

Structure
REQ-036 A shared package shall hold the TX state enum (TX_IDLE, TX_WAIT) and the constants CMD_BYTES=3, HI_IDX=0, MID_IDX=1, LO_IDX=2.
REQ-037 The TX handshake shall be a sub-module, resp_tx_ctrl, instantiated once.
REQ-038 The timeout counter width shall be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-039 Bytes 0x02,0x10,0xA5 on rx_rdy -> cmd=0x0210A5 and cmd_rdy=1 one clock after the third pulse.
REQ-040 With cmd_rdy=1, send byte 0x55 -> cmd unchanged and rx_overrun=1; then clr_cmd_rdy -> cmd_rdy=0 and rx_overrun=0 next clock.
REQ-041 With TIMEOUT_CYCLES=16, send 0x01, wait 16 idle clocks, then send 0x0A,0x0B,0x0C -> cmd=0x0A0B0C.
REQ-042 send_resp with resp_data=0xA5 -> tx_data=0xA5, one trmt pulse, resp_busy=1; a second send_resp with 0x5A is ignored; tx_done -> one resp_sent pulse and resp_busy=0.
REQ-043 Assert rst after the second byte and during TX_WAIT -> all outputs at reset values; then three new bytes yield a correct cmd, and a stray tx_done yields no resp_sent.
REQ-044 clr_cmd_rdy coincident with a first byte 0x7F -> byte accepted as index 0 and no overrun.

Source files
------------

// File: rtl/host_cmd_link_pkg.sv
// host_cmd_link_pkg
//   Shared types and constants for the host command link: TX handshake
//   state encoding and the byte-index constants of the 3-byte command.
package host_cmd_link_pkg;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

  localparam int         CMD_BYTES = 3;
  localparam logic [1:0] HI_IDX    = 2'd0;
  localparam logic [1:0] MID_IDX   = 2'd1;
  localparam logic [1:0] LO_IDX    = 2'd2;

endpackage

// File: rtl/host_cmd_link_if.sv
// host_cmd_link_if
//   Bundles the UART-side and core-side signals of host_cmd_link.
//   master : host/core side (drives rx bytes, clears, response requests)
//   slave  : host_cmd_link itself
//   Signals: rx_data/rx_rdy (UART rx byte), cmd/cmd_rdy/clr_cmd_rdy (command
//   to core), resp_data/send_resp/resp_sent/resp_busy (response request),
//   tx_data/trmt/tx_done (UART tx), rx_overrun (sticky dropped-byte flag).
interface host_cmd_link_if;
  import host_cmd_link_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_busy;
  logic        rx_overrun;

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    input  cmd, cmd_rdy, resp_sent, tx_data, trmt, resp_busy, rx_overrun
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    output cmd, cmd_rdy, resp_sent, tx_data, trmt, resp_busy, rx_overrun
  );

endinterface

// File: rtl/host_cmd_link_resp_tx_ctrl.sv
// resp_tx_ctrl
//   Response transmit handshake: latches one response byte, kicks the UART
//   transmitter with a one-cycle trmt, and reports completion with a
//   one-cycle resp_sent when the transmitter signals tx_done.
//   Ports: clk, rst (sync, active-high), i_send_resp, i_resp_data, i_tx_done,
//          o_tx_data, o_trmt, o_resp_sent, o_resp_busy.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   TX_IDLE | no response in flight; accepts send_resp
//   TX_WAIT | byte handed to UART; waiting for tx_done
module resp_tx_ctrl
  import host_cmd_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send_resp,
  input  logic [7:0] i_resp_data,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_data,
  output logic       o_trmt,
  output logic       o_resp_sent,
  output logic       o_resp_busy
);

  tx_state_t  r_state, w_state_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_trmt, w_trmt_nxt;
  logic       r_resp_sent, w_resp_sent_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_tx_data   <= 8'h00;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_trmt      <= w_trmt_nxt;
      r_resp_sent <= w_resp_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_data_nxt   = r_tx_data;
    w_trmt_nxt      = 1'b0;
    w_resp_sent_nxt = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_send_resp) begin
          w_tx_data_nxt = i_resp_data;
          w_trmt_nxt    = 1'b1;
          w_state_nxt   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_tx_done) begin
          w_resp_sent_nxt = 1'b1;
          w_state_nxt     = TX_IDLE;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign o_tx_data   = r_tx_data;
  assign o_trmt      = r_trmt;
  assign o_resp_sent = r_resp_sent;
  assign o_resp_busy = (r_state == TX_WAIT);

endmodule

// File: rtl/host_cmd_link.sv
// host_cmd_link
//   Assembles 3-byte host commands (MSB first) from UART rx bytes, holds each
//   command for the core until cleared, discards stale partial commands after
//   TIMEOUT_CYCLES idle clocks, and forwards single response bytes to the
//   UART transmitter via resp_tx_ctrl.
//   Ports: clk, rst (sync, active-high), bus (host_cmd_link_if.slave).
module host_cmd_link
  import host_cmd_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int NUM_CMD_BYTES  = 3
) (
  input  logic           clk,
  input  logic           rst,
  host_cmd_link_if.slave bus
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     LAST_IDX = 2'(NUM_CMD_BYTES - 1);

  logic [1:0]    r_idx;
  logic [TW-1:0] r_to_cnt;
  logic [23:0]   r_cmd;
  logic          r_cmd_rdy;
  logic          r_overrun;

  logic w_clr, w_accept, w_drop, w_timeout;

  // A clear coincident with a new byte frees the holding register in the
  // same edge, so that byte is taken as the first of the next command.
  assign w_clr     = r_cmd_rdy & bus.clr_cmd_rdy;
  assign w_accept  = bus.rx_rdy & (~r_cmd_rdy | bus.clr_cmd_rdy);
  assign w_drop    = bus.rx_rdy & r_cmd_rdy & ~bus.clr_cmd_rdy;
  // r_to_cnt counts idle clocks already elapsed; this edge is the final one.
  assign w_timeout = (r_idx != HI_IDX) & ~w_accept & (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= HI_IDX;
      r_to_cnt  <= '0;
      r_cmd     <= 24'h000000;
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        case (r_idx)
          HI_IDX:  r_cmd[23:16] <= bus.rx_data;
          MID_IDX: r_cmd[15:8]  <= bus.rx_data;
          default: r_cmd[7:0]   <= bus.rx_data;
        endcase
        r_idx <= (r_idx == LAST_IDX) ? HI_IDX : r_idx + 2'd1;
      end else if (w_timeout) begin
        r_idx <= HI_IDX;
      end

      if (w_accept || (r_idx == HI_IDX) || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_accept && (r_idx == LAST_IDX))
        r_cmd_rdy <= 1'b1;
      else if (w_clr)
        r_cmd_rdy <= 1'b0;

      if (w_clr)
        r_overrun <= 1'b0;
      else if (w_drop)
        r_overrun <= 1'b1;
    end
  end

  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.rx_overrun = r_overrun;

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_send_resp (bus.send_resp),
    .i_resp_data (bus.resp_data),
    .i_tx_done   (bus.tx_done),
    .o_tx_data   (bus.tx_data),
    .o_trmt      (bus.trmt),
    .o_resp_sent (bus.resp_sent),
    .o_resp_busy (bus.resp_busy)
  );

endmodule

// File: tb/tb_host_cmd_link.sv
module tb_host_cmd_link;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  host_cmd_link_if bus();

  host_cmd_link #(.TIMEOUT_CYCLES(TO), .NUM_CMD_BYTES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the link should look like after each edge.
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  logic [23:0] m_cmd  = 24'h0;
  bit          m_pend = 0, m_ovr = 0, m_busy = 0, m_trmt = 0, m_sent = 0;
  logic [7:0]  m_tx   = 8'h0;

  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, updated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    bit was_pend;
    int k;
    if (rst) begin
      m_part.delete();
      m_idle = 0; m_cmd = 24'h0; m_pend = 0; m_ovr = 0;
      m_busy = 0; m_tx = 8'h0; m_trmt = 0; m_sent = 0;
    end else begin
      m_trmt = 0;
      m_sent = 0;
      was_pend = m_pend;
      if (was_pend && bus.clr_cmd_rdy) begin
        m_pend = 0;
        m_ovr  = 0;
      end
      if (was_pend && bus.rx_rdy && !bus.clr_cmd_rdy)
        m_ovr = 1;
      if (bus.rx_rdy && (!was_pend || bus.clr_cmd_rdy)) begin
        k = m_part.size();
        m_cmd[23 - 8*k -: 8] = bus.rx_data;
        m_part.push_back(bus.rx_data);
        m_idle = 0;
        if (m_part.size() == 3) begin
          m_pend = 1;
          exp_cmd_q.push_back({m_part[0], m_part[1], m_part[2]});
          m_part.delete();
        end
      end else if (m_part.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_part.delete();
          m_idle = 0;
        end
      end
      if (!m_busy && bus.send_resp) begin
        m_tx   = bus.resp_data;
        m_trmt = 1;
        m_busy = 1;
        exp_tx_q.push_back(bus.resp_data);
      end else if (m_busy && bus.tx_done) begin
        m_sent = 1;
        m_busy = 0;
      end
    end
  end

  // Monitor: compares on the falling edge, pops scoreboard entries on events.
  bit prev_rdy = 0;
  always @(negedge clk) begin
    chk("cmd_rdy",    bus.cmd_rdy,    m_pend);
    chk("rx_overrun", bus.rx_overrun, m_ovr);
    chk("cmd",        bus.cmd,        m_cmd);
    chk("resp_busy",  bus.resp_busy,  m_busy);
    chk("trmt",       bus.trmt,       m_trmt);
    chk("resp_sent",  bus.resp_sent,  m_sent);
    chk("tx_data",    bus.tx_data,    m_tx);
    if (bus.cmd_rdy && !prev_rdy) begin
      if (exp_cmd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_sb: cmd_rdy rose with cmd %0h, no command expected", bus.cmd);
      end else begin
        chk("cmd_sb", bus.cmd, exp_cmd_q.pop_front());
      end
    end
    if (bus.trmt) begin
      if (exp_tx_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL tx_sb: trmt with tx_data %0h, no response expected", bus.tx_data);
      end else begin
        chk("tx_sb", bus.tx_data, exp_tx_q.pop_front());
      end
    end
    prev_rdy = bus.cmd_rdy;
  end

  task automatic drive(input bit rr, input logic [7:0] rd, input bit clr,
                       input bit sr, input logic [7:0] rsp, input bit td);
    bus.rx_rdy = rr; bus.rx_data = rd; bus.clr_cmd_rdy = clr;
    bus.send_resp = sr; bus.resp_data = rsp; bus.tx_done = td;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1, b, 0, 0, 8'h00, 0);
  endtask

  task automatic clear();
    drive(0, 8'h00, 1, 0, 8'h00, 0);
  endtask

  initial begin
    bus.rx_rdy = 0; bus.rx_data = 0; bus.clr_cmd_rdy = 0;
    bus.send_resp = 0; bus.resp_data = 0; bus.tx_done = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", bus.cmd, 24'h0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    rst = 0;
    idle(2);

    // Basic assembly
    send_byte(8'h02); send_byte(8'h10);
    chk("two_bytes_rdy", bus.cmd_rdy, 0);
    send_byte(8'hA5);
    chk("asm_cmd", bus.cmd, 24'h0210A5);
    chk("asm_rdy", bus.cmd_rdy, 1);

    // Overrun while held, then clear
    send_byte(8'h55);
    chk("ovr_cmd_held", bus.cmd, 24'h0210A5);
    chk("ovr_flag", bus.rx_overrun, 1);
    clear();
    chk("clr_rdy", bus.cmd_rdy, 0);
    chk("clr_ovr", bus.rx_overrun, 0);
    clear();
    chk("clr_noop_cmd", bus.cmd, 24'h0210A5);

    // Clear coincident with first byte
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    drive(1, 8'h7F, 1, 0, 8'h00, 0);
    chk("coinc_rdy", bus.cmd_rdy, 0);
    chk("coinc_ovr", bus.rx_overrun, 0);
    chk("coinc_hi", bus.cmd[23:16], 8'h7F);
    send_byte(8'h01); send_byte(8'h02);
    chk("coinc_cmd", bus.cmd, 24'h7F0102);
    clear();

    // Timeout boundary: 16 idle clocks discard, 15 do not
    send_byte(8'h01); idle(TO);
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    chk("to_cmd", bus.cmd, 24'h0A0B0C);
    chk("to_rdy", bus.cmd_rdy, 1);
    clear();
    send_byte(8'h01); idle(TO - 1);
    send_byte(8'h0A); send_byte(8'h0B);
    chk("no_to_cmd", bus.cmd, 24'h010A0B);
    clear();

    // Response handshake
    drive(0, 8'h00, 0, 1, 8'hA5, 0);
    chk("resp_tx", bus.tx_data, 8'hA5);
    chk("resp_trmt", bus.trmt, 1);
    chk("resp_busy", bus.resp_busy, 1);
    drive(0, 8'h00, 0, 1, 8'h5A, 0);
    chk("resp_ign_trmt", bus.trmt, 0);
    chk("resp_ign_tx", bus.tx_data, 8'hA5);
    idle(2);
    drive(0, 8'h00, 0, 0, 8'h00, 1);
    chk("resp_sent", bus.resp_sent, 1);
    chk("resp_idle", bus.resp_busy, 0);
    idle(1);
    chk("resp_sent_pulse", bus.resp_sent, 0);

    // Reset mid-command and mid-response
    send_byte(8'h01); send_byte(8'h02);
    drive(0, 8'h00, 0, 1, 8'h3C, 0);
    rst = 1;
    idle(1);
    chk("mrst_cmd", bus.cmd, 24'h0);
    chk("mrst_busy", bus.resp_busy, 0);
    chk("mrst_tx", bus.tx_data, 8'h00);
    rst = 0;
    drive(0, 8'h00, 0, 0, 8'h00, 1);
    chk("mrst_stray_done", bus.resp_sent, 0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    chk("mrst_cmd_new", bus.cmd, 24'hAABBCC);
    clear();

    // Randomized traffic on both paths
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) idle($urandom_range(TO + 1, TO - 1));
      if ($urandom_range(499) == 0) begin
        rst = 1; idle(1); rst = 0;
      end
      drive($urandom_range(3) == 0, 8'($urandom), $urandom_range(5) == 0,
            $urandom_range(4) == 0, 8'($urandom), $urandom_range(4) == 0);
    end
    idle(3);
    chk("cmd_q_drained", exp_cmd_q.size(), 0);
    chk("tx_q_drained", exp_tx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
